pi_bus_arbiter: RTL and testbench
=================================

Name: pi_bus_arbiter

Overview:
- Downstream consumer of the Pi SPI command decoder's memory request (pi_addr/pi_data_out/pi_rw_b/pi_pending level, pi_done level back).
- Time-slices the shared 128KB SRAM bus between the 6502 CPU and the Pi.
- Fixed bus cycle of CYCLE_LEN sys_clk cycles: CPU slot first, then Pi slot.
- Performs at most one Pi access per bus cycle and returns read data plus a done handshake.

Parameters:
CYCLE_LEN, 64, sys_clk cycles per bus cycle (64 MHz / 64 = 1 MHz CPU)
CPU_STROBE_START, 8, first cycle_count of CPU RAM strobe
CPU_STROBE_END, 24, cycle_count one past last CPU strobe cycle
PI_START, 32, first cycle_count of Pi slot
PI_STROBE_START, 36, first cycle_count of Pi RAM strobe
PI_STROBE_END, 52, cycle_count one past last Pi strobe cycle
Constraint (elaboration error otherwise): CPU_STROBE_START < CPU_STROBE_END < PI_START < PI_STROBE_START < PI_STROBE_END < CYCLE_LEN.

Ports:
sys_clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_en  in  1  CPU wants RAM this bus cycle (sampled at cycle_count==0)
cpu_addr  in  17  CPU RAM address
cpu_rw_b  in  1  1=read, 0=write
cpu_data_out  in  8  CPU write data
cpu_data_in  out  8  captured CPU read data
cpu_clk_en  out  1  one-cycle pulse at bus cycle end
pi_addr  in  17  Pi request address
pi_rw_b  in  1  Pi request direction
pi_data_out  in  8  Pi write data
pi_pending  in  1  Pi request level
pi_data_in  out  8  captured Pi read data
pi_done  out  1  Pi access complete (level)
ram_addr  out  17  SRAM address
ram_data_out  out  8  SRAM write data
ram_data_oe  out  1  drive SRAM data bus
ram_data_in  in  8  SRAM read data
ram_we_b  out  1  SRAM write strobe, active low
ram_oe_b  out  1  SRAM output enable, active low
cycle_count  out  6  debug: position in bus cycle ($clog2(CYCLE_LEN))
state  out  2  debug: FSM state

Behaviour:
- Reset: cycle_count=0, state=CPU, ram_we_b=1, ram_oe_b=1, ram_data_oe=0, ram_addr=0, ram_data_out=0, cpu_data_in=0, pi_data_in=0, pi_done=0, cpu_clk_en=0. Reset mid-strobe deasserts strobes the next cycle; no done is issued.
- All outputs registered. "In cycle N" means the output value while cycle_count==N.
- cycle_count increments every sys_clk and wraps CYCLE_LEN-1 -> 0.
- cpu_clk_en=1 only in cycle CYCLE_LEN-1.
- States: CPU(0), PI(1), IDLE(2).
- CPU state:
  - ram_addr=cpu_addr latched at count 0.
  - If cpu_en was latched: in [CPU_STROBE_START, CPU_STROBE_END), assert ram_oe_b=0 for a read or ram_we_b=0 for a write.
  - Write: ram_data_oe=1 in [CPU_STROBE_START, CPU_STROBE_END], one hold cycle past we_b.
  - Read: cpu_data_in <= ram_data_in at count CPU_STROBE_END-1.
- At count PI_START-1, if pi_pending && !pi_done: latch pi_addr/pi_rw_b/pi_data_out, go to PI. Otherwise go to IDLE.
- PI state:
  - Same strobe and data_oe rules using PI_STROBE_START/END and latched values.
  - Read: pi_data_in <= ram_data_in at PI_STROBE_END-1.
  - At PI_STROBE_END: pi_done <= pi_pending, then go to IDLE.
  - pi_pending falling mid-access: the strobe completes untruncated and pi_done stays 0.
- IDLE: strobes high, data_oe=0, ram_addr held. At CYCLE_LEN-1 go to CPU.
- pi_done handshake:
  - Holds 1 while pi_pending=1.
  - Clears the cycle after pi_pending=0.
  - No second access while pi_done=1.
  - pi_pending rising after the PI_START-1 sample is served in the next bus cycle.
- Strobe exclusivity: ram_we_b and ram_oe_b are never both low. Pi and CPU strobes never overlap.
- pi_data_in and cpu_data_in hold their values until the next read of the same requester.

Test Plan:
- Reset, then idle 3 bus cycles -> cpu_clk_en pulses every 64 clocks at count 63; ram_we_b/ram_oe_b stay 1; pi_done=0.
- CPU write cpu_en=1, addr=0x08000, data=0xA5 -> ram_we_b=0 in counts 8..23, ram_data_oe=1 in 8..24, ram_addr=0x08000; preload model then CPU read returns 0xA5 in cpu_data_in after count 23.
- Pi write: pi_pending=1 before count 31, addr=0x1E000, data=0x3C, rw_b=0 -> ram_we_b=0 in counts 36..51; pi_done=1 from count 52; hold pending 2 more bus cycles -> no further strobes; drop pending -> pi_done=0 next clock.
- Pi read of 0x1E000 after the write -> pi_data_in=0x3C when pi_done rises; concurrent CPU read of 0x00010 in the same bus cycle gets its own data with no strobe overlap.
- pi_pending rises at count 40 -> no Pi strobe that bus cycle; access at counts 36..51 of the next cycle; pending dropped at count 45 of that cycle -> strobe runs through 51, pi_done stays 0.
- Assert reset at count 40 during a Pi write -> next clock ram_we_b=1, ram_data_oe=0, count=0, pi_done=0.

Source files
------------

// File: rtl/pi_bus_arbiter.sv
// rtl/pi_bus_arbiter.sv - time-sliced SRAM bus arbiter between the 6502 CPU and the Pi
//
// Ports:
//   sys_clk, reset            system clock, synchronous active-high reset
//   cpu_en, cpu_addr,         CPU slot request, sampled at cycle_count 0
//   cpu_rw_b, cpu_data_out
//   cpu_data_in               captured CPU read data
//   cpu_clk_en                one-cycle pulse in the last cycle of each bus cycle
//   pi_addr, pi_rw_b,         Pi request, held while pi_pending is high
//   pi_data_out, pi_pending
//   pi_data_in, pi_done       captured Pi read data, completion level
//   ram_addr, ram_data_out,   SRAM address, write data and data bus drive
//   ram_data_oe
//   ram_data_in               SRAM read data
//   ram_we_b, ram_oe_b        SRAM strobes, active low
//   cycle_count, state        debug: position in bus cycle, FSM state

module pi_bus_arbiter #(
  parameter int CYCLE_LEN        = 64,
  parameter int CPU_STROBE_START = 8,
  parameter int CPU_STROBE_END   = 24,
  parameter int PI_START         = 32,
  parameter int PI_STROBE_START  = 36,
  parameter int PI_STROBE_END    = 52
) (
  input  logic                         sys_clk,
  input  logic                         reset,
  input  logic                         cpu_en,
  input  logic [16:0]                  cpu_addr,
  input  logic                         cpu_rw_b,
  input  logic [7:0]                   cpu_data_out,
  output logic [7:0]                   cpu_data_in,
  output logic                         cpu_clk_en,
  input  logic [16:0]                  pi_addr,
  input  logic                         pi_rw_b,
  input  logic [7:0]                   pi_data_out,
  input  logic                         pi_pending,
  output logic [7:0]                   pi_data_in,
  output logic                         pi_done,
  output logic [16:0]                  ram_addr,
  output logic [7:0]                   ram_data_out,
  output logic                         ram_data_oe,
  input  logic [7:0]                   ram_data_in,
  output logic                         ram_we_b,
  output logic                         ram_oe_b,
  output logic [$clog2(CYCLE_LEN)-1:0] cycle_count,
  output logic [1:0]                   state
);

  localparam int CW = $clog2(CYCLE_LEN);

  localparam logic [CW-1:0] C_LAST   = CW'(CYCLE_LEN - 1);
  localparam logic [CW-1:0] C_CSS    = CW'(CPU_STROBE_START);
  localparam logic [CW-1:0] C_CSE    = CW'(CPU_STROBE_END);
  localparam logic [CW-1:0] C_CSE_M1 = CW'(CPU_STROBE_END - 1);
  localparam logic [CW-1:0] C_PST_M1 = CW'(PI_START - 1);
  localparam logic [CW-1:0] C_PSS    = CW'(PI_STROBE_START);
  localparam logic [CW-1:0] C_PSE    = CW'(PI_STROBE_END);
  localparam logic [CW-1:0] C_PSE_M1 = CW'(PI_STROBE_END - 1);

  if (!(CPU_STROBE_START < CPU_STROBE_END && CPU_STROBE_END < PI_START &&
        PI_START < PI_STROBE_START && PI_STROBE_START < PI_STROBE_END &&
        PI_STROBE_END < CYCLE_LEN)) begin : g_param_check
    $error("pi_bus_arbiter: slot boundaries out of order");
  end

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,
    ST_PI   = 2'd1,
    ST_IDLE = 2'd2
  } state_t;

  state_t        state_q, nxt_state;
  logic          cpu_en_q, cpu_rw_q, pi_rw_q;
  logic [CW-1:0] nxt_count;
  logic          cpu_en_eff, cpu_rw_eff, pi_take, pi_rw_eff;
  logic          nxt_we_b, nxt_oe_b, nxt_doe;
  logic [16:0]   nxt_addr;
  logic [7:0]    nxt_wdata;

  assign state = state_q;

  // Every output is registered, so the next-cycle value of each output is
  // derived here from the count and state the design is about to enter.
  always_comb begin
    nxt_count  = (cycle_count == C_LAST) ? '0 : cycle_count + 1'b1;
    // The CPU request is latched on the edge leaving count 0; use it as it
    // is being latched so the window decode never sees a stale request.
    cpu_en_eff = (cycle_count == '0) ? cpu_en : cpu_en_q;
    cpu_rw_eff = (cycle_count == '0) ? cpu_rw_b : cpu_rw_q;
    // A completed request (pi_done still high) is never served twice.
    pi_take    = (state_q == ST_CPU) && (cycle_count == C_PST_M1) && pi_pending && !pi_done;
    pi_rw_eff  = pi_take ? pi_rw_b : pi_rw_q;

    nxt_state = state_q;
    case (state_q)
      ST_CPU:  if (cycle_count == C_PST_M1) nxt_state = pi_take ? ST_PI : ST_IDLE;
      ST_PI:   if (cycle_count == C_PSE) nxt_state = ST_IDLE;
      ST_IDLE: if (cycle_count == C_LAST) nxt_state = ST_CPU;
      default: nxt_state = ST_IDLE;
    endcase

    nxt_addr  = ram_addr;
    nxt_wdata = ram_data_out;
    if (cycle_count == '0) begin
      nxt_addr  = cpu_addr;
      nxt_wdata = cpu_data_out;
    end else if (pi_take) begin
      nxt_addr  = pi_addr;
      nxt_wdata = pi_data_out;
    end

    // Write data is driven one cycle past the write strobe for hold time.
    nxt_we_b = 1'b1;
    nxt_oe_b = 1'b1;
    nxt_doe  = 1'b0;
    if (nxt_state == ST_CPU && cpu_en_eff) begin
      if (nxt_count >= C_CSS && nxt_count < C_CSE) begin
        nxt_oe_b = !cpu_rw_eff;
        nxt_we_b = cpu_rw_eff;
      end
      nxt_doe = !cpu_rw_eff && nxt_count >= C_CSS && nxt_count <= C_CSE;
    end else if (nxt_state == ST_PI) begin
      if (nxt_count >= C_PSS && nxt_count < C_PSE) begin
        nxt_oe_b = !pi_rw_eff;
        nxt_we_b = pi_rw_eff;
      end
      nxt_doe = !pi_rw_eff && nxt_count >= C_PSS && nxt_count <= C_PSE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q      <= ST_CPU;
      cycle_count  <= '0;
      cpu_clk_en   <= 1'b0;
      ram_we_b     <= 1'b1;
      ram_oe_b     <= 1'b1;
      ram_data_oe  <= 1'b0;
      ram_addr     <= '0;
      ram_data_out <= '0;
      cpu_data_in  <= '0;
      pi_data_in   <= '0;
      pi_done      <= 1'b0;
      cpu_en_q     <= 1'b0;
      cpu_rw_q     <= 1'b1;
      pi_rw_q      <= 1'b1;
    end else begin
      state_q      <= nxt_state;
      cycle_count  <= nxt_count;
      cpu_clk_en   <= (nxt_count == C_LAST);
      ram_we_b     <= nxt_we_b;
      ram_oe_b     <= nxt_oe_b;
      ram_data_oe  <= nxt_doe;
      ram_addr     <= nxt_addr;
      ram_data_out <= nxt_wdata;
      if (cycle_count == '0) begin
        cpu_en_q <= cpu_en;
        cpu_rw_q <= cpu_rw_b;
      end
      if (pi_take) pi_rw_q <= pi_rw_b;
      if (state_q == ST_CPU && cycle_count == C_CSE_M1 && cpu_en_q && cpu_rw_q)
        cpu_data_in <= ram_data_in;
      if (state_q == ST_PI && cycle_count == C_PSE_M1 && pi_rw_q)
        pi_data_in <= ram_data_in;
      // A request withdrawn mid-access finishes its strobe but reports no done.
      if (state_q == ST_PI && cycle_count == C_PSE_M1)
        pi_done <= pi_pending;
      else if (!pi_pending)
        pi_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pi_bus_arbiter.sv
// tb/tb_pi_bus_arbiter.sv - self-checking bench for pi_bus_arbiter

module tb_pi_bus_arbiter;

  localparam int LEN = 64;
  localparam int CSS = 8, CSE = 24, PST = 32, PSS = 36, PSE = 52;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_en = 1'b0;
  logic [16:0] cpu_addr = '0;
  logic        cpu_rw_b = 1'b1;
  logic [7:0]  cpu_data_out = '0;
  logic [7:0]  cpu_data_in;
  logic        cpu_clk_en;
  logic [16:0] pi_addr = '0;
  logic        pi_rw_b = 1'b1;
  logic [7:0]  pi_data_out = '0;
  logic        pi_pending = 1'b0;
  logic [7:0]  pi_data_in;
  logic        pi_done;
  logic [16:0] ram_addr;
  logic [7:0]  ram_data_out;
  logic        ram_data_oe;
  logic [7:0]  ram_data_in;
  logic        ram_we_b;
  logic        ram_oe_b;
  logic [5:0]  cycle_count;
  logic [1:0]  state;

  pi_bus_arbiter dut (
    .sys_clk(sys_clk), .reset(reset),
    .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_rw_b(cpu_rw_b),
    .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in), .cpu_clk_en(cpu_clk_en),
    .pi_addr(pi_addr), .pi_rw_b(pi_rw_b), .pi_data_out(pi_data_out),
    .pi_pending(pi_pending), .pi_data_in(pi_data_in), .pi_done(pi_done),
    .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_oe(ram_data_oe),
    .ram_data_in(ram_data_in), .ram_we_b(ram_we_b), .ram_oe_b(ram_oe_b),
    .cycle_count(cycle_count), .state(state)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Physical SRAM driven by the DUT pins, and the reference memory the model updates.
  logic [7:0] sram    [0:131071];
  logic [7:0] ref_mem [0:131071];

  assign ram_data_in = ram_oe_b ? 8'hEE : sram[ram_addr];

  function automatic logic [7:0] preload(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one record per bus cycle for each requester.
  bit          m_live = 0;
  int          m_n = 0;
  bit          m_cpu_req, m_cpu_rd;
  logic [16:0] m_cpu_addr;
  logic [7:0]  m_cpu_wd;
  bit          m_pi_go, m_pi_rd;
  logic [16:0] m_pi_addr;
  logic [7:0]  m_pi_wd;
  logic [16:0] m_addr;
  logic [7:0]  m_wd;
  bit          m_done;
  logic [7:0]  m_cpu_din, m_pi_din;

  always @(posedge sys_clk) begin
    if (!ram_we_b) sram[ram_addr] = ram_data_out;
    if (reset) begin
      m_live = 1; m_n = 0;
      m_cpu_req = 0; m_cpu_rd = 1; m_cpu_addr = '0; m_cpu_wd = '0;
      m_pi_go = 0; m_pi_rd = 1; m_pi_addr = '0; m_pi_wd = '0;
      m_addr = '0; m_wd = '0; m_done = 0; m_cpu_din = '0; m_pi_din = '0;
    end else if (m_live) begin
      if (m_n == CSE - 1 && m_cpu_req) begin
        if (m_cpu_rd) m_cpu_din = ref_mem[m_cpu_addr];
        else ref_mem[m_cpu_addr] = m_cpu_wd;
      end
      if (m_n == PSE - 1 && m_pi_go) begin
        if (m_pi_rd) m_pi_din = ref_mem[m_pi_addr];
        else ref_mem[m_pi_addr] = m_pi_wd;
      end
      if (m_n == PSE - 1 && m_pi_go) m_done = pi_pending;
      else if (!pi_pending) m_done = 0;
      if (m_n == PST - 1) begin
        m_pi_go = pi_pending && !m_done;
        if (m_pi_go) begin
          m_pi_rd = pi_rw_b; m_pi_addr = pi_addr; m_pi_wd = pi_data_out;
          m_addr = pi_addr; m_wd = pi_data_out;
        end
      end
      if (m_n == 0) begin
        m_cpu_req = cpu_en; m_cpu_rd = cpu_rw_b; m_cpu_addr = cpu_addr; m_cpu_wd = cpu_data_out;
        m_addr = cpu_addr; m_wd = cpu_data_out;
      end
      if (m_n == LEN - 1) m_pi_go = 0;
      m_n = (m_n + 1) % LEN;
    end
  end

  always @(negedge sys_clk) begin : compare
    bit cpu_win, cpu_hold, pi_win, pi_hold;
    bit e_we_b, e_oe_b, e_doe;
    int e_state;
    if (m_live) begin
      cpu_win  = m_cpu_req && m_n >= CSS && m_n < CSE;
      cpu_hold = m_cpu_req && m_n >= CSS && m_n <= CSE;
      pi_win   = m_pi_go && m_n >= PSS && m_n < PSE;
      pi_hold  = m_pi_go && m_n >= PSS && m_n <= PSE;
      e_we_b   = !((cpu_win && !m_cpu_rd) || (pi_win && !m_pi_rd));
      e_oe_b   = !((cpu_win && m_cpu_rd) || (pi_win && m_pi_rd));
      e_doe    = (cpu_hold && !m_cpu_rd) || (pi_hold && !m_pi_rd);
      e_state  = (m_n < PST) ? 0 : (m_pi_go && m_n <= PSE) ? 1 : 2;
      check("cycle_count", 32'(cycle_count), m_n);
      check("state", 32'(state), e_state);
      check("cpu_clk_en", 32'(cpu_clk_en), (m_n == LEN - 1) ? 1 : 0);
      check("ram_we_b", 32'(ram_we_b), 32'(e_we_b));
      check("ram_oe_b", 32'(ram_oe_b), 32'(e_oe_b));
      check("ram_data_oe", 32'(ram_data_oe), 32'(e_doe));
      check("ram_addr", 32'(ram_addr), 32'(m_addr));
      if (e_doe) check("ram_data_out", 32'(ram_data_out), 32'(m_wd));
      check("cpu_data_in", 32'(cpu_data_in), 32'(m_cpu_din));
      check("pi_data_in", 32'(pi_data_in), 32'(m_pi_din));
      check("pi_done", 32'(pi_done), 32'(m_done));
    end
  end

  task automatic wait_n(input int n);
    int guard;
    guard = 0;
    do begin
      @(negedge sys_clk);
      guard++;
    end while (m_n != n && guard < 200);
    if (m_n != n) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_n: count %0d required %0d", m_n, n);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int pulses, strobes;
    for (int a = 0; a < 131072; a++) begin
      sram[a]    = preload(a);
      ref_mem[a] = preload(a);
    end

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_count", 32'(cycle_count), 0);
    check("rst_we_b", 32'(ram_we_b), 1);
    check("rst_oe_b", 32'(ram_oe_b), 1);
    check("rst_pi_done", 32'(pi_done), 0);
    check("rst_clk_en", 32'(cpu_clk_en), 0);
    reset = 1'b0;

    // Three idle bus cycles: one cpu_clk_en pulse each, no strobes
    pulses = 0; strobes = 0;
    for (int i = 0; i < 3 * LEN; i++) begin
      if (cpu_clk_en) pulses++;
      if (!ram_we_b || !ram_oe_b) strobes++;
      @(negedge sys_clk);
    end
    check("idle_pulses", pulses, 3);
    check("idle_strobes", strobes, 0);

    // CPU write then read back
    wait_n(0);
    cpu_en = 1; cpu_rw_b = 0; cpu_addr = 17'h08000; cpu_data_out = 8'hA5;
    wait_n(8);  check("cpu_wr_we_b_8", 32'(ram_we_b), 0); check("cpu_wr_addr", 32'(ram_addr), 'h08000);
    wait_n(23); check("cpu_wr_we_b_23", 32'(ram_we_b), 0);
    wait_n(24); check("cpu_wr_we_b_24", 32'(ram_we_b), 1); check("cpu_wr_doe_24", 32'(ram_data_oe), 1);
    wait_n(25); check("cpu_wr_doe_25", 32'(ram_data_oe), 0);
    wait_n(0);  cpu_rw_b = 1;
    wait_n(12); check("cpu_rd_oe_b", 32'(ram_oe_b), 0);
    wait_n(24); check("cpu_rd_data", 32'(cpu_data_in), 'hA5);
    cpu_en = 0;

    // Pi write, held pending, then released
    wait_n(20);
    pi_pending = 1; pi_rw_b = 0; pi_addr = 17'h1E000; pi_data_out = 8'h3C;
    wait_n(36); check("pi_wr_we_b_36", 32'(ram_we_b), 0); check("pi_wr_addr", 32'(ram_addr), 'h1E000);
    wait_n(51); check("pi_wr_done_51", 32'(pi_done), 0);
    wait_n(52); check("pi_wr_done_52", 32'(pi_done), 1);
    strobes = 0;
    repeat (2 * LEN) begin
      @(negedge sys_clk);
      if (!ram_we_b || !ram_oe_b) strobes++;
    end
    check("pi_hold_strobes", strobes, 0);
    check("pi_hold_done", 32'(pi_done), 1);
    wait_n(10); pi_pending = 0;
    @(negedge sys_clk); check("pi_done_clear", 32'(pi_done), 0);

    // Pi read alongside a CPU read in the same bus cycle
    wait_n(0);
    cpu_en = 1; cpu_rw_b = 1; cpu_addr = 17'h00010;
    pi_pending = 1; pi_rw_b = 1; pi_addr = 17'h1E000;
    wait_n(24); check("cpu_rd_preload", 32'(cpu_data_in), 'h4A);
    wait_n(52); check("pi_rd_data", 32'(pi_data_in), 'h3C); check("pi_rd_done", 32'(pi_done), 1);
    cpu_en = 0; pi_pending = 0;

    // Late request, then withdrawn mid-access
    wait_n(40);
    pi_pending = 1; pi_rw_b = 0; pi_addr = 17'h00123; pi_data_out = 8'h77;
    wait_n(44); check("late_no_strobe", 32'(ram_we_b), 1);
    wait_n(36); check("late_served_36", 32'(ram_we_b), 0);
    wait_n(45); pi_pending = 0;
    wait_n(51); check("drop_strobe_51", 32'(ram_we_b), 0);
    wait_n(52); check("drop_no_done", 32'(pi_done), 0); check("drop_we_b_52", 32'(ram_we_b), 1);

    // Reset in the middle of a Pi write strobe
    wait_n(10);
    pi_pending = 1; pi_rw_b = 0; pi_addr = 17'h1F0F0; pi_data_out = 8'h99;
    wait_n(40); check("prerst_we_b", 32'(ram_we_b), 0);
    reset = 1;
    @(negedge sys_clk);
    check("midrst_we_b", 32'(ram_we_b), 1);
    check("midrst_doe", 32'(ram_data_oe), 0);
    check("midrst_count", 32'(cycle_count), 0);
    check("midrst_done", 32'(pi_done), 0);
    reset = 0; pi_pending = 0;

    // Randomised traffic over a small shared address window
    for (int c = 0; c < 40 * LEN; c++) begin
      @(negedge sys_clk);
      if (m_n == LEN - 1) begin
        cpu_en = 1'($urandom_range(0, 1));
        cpu_rw_b = 1'($urandom_range(0, 1));
        cpu_addr = 17'h00100 + 17'($urandom_range(0, 7));
        cpu_data_out = 8'($urandom);
      end
      if (!pi_pending) begin
        if ($urandom_range(0, 29) == 0) begin
          pi_pending = 1;
          pi_rw_b = 1'($urandom_range(0, 1));
          pi_addr = 17'h00100 + 17'($urandom_range(0, 7));
          pi_data_out = 8'($urandom);
        end
      end else if (pi_done ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0)) begin
        pi_pending = 0;
      end
    end

    @(negedge sys_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
